// File: rtl/vote_display_driver.sv
// Binary-to-BCD display driver: a sequential double-dabble converter feeding a
// time-multiplexed 4-digit common-anode seven-segment display.
module vote_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  value,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    logic [1:0]       state;
    logic [9:0]       last_value;
    logic [9:0]       shift;
    logic [15:0]      work;
    logic [3:0]       iter;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       cur_digit;
    logic             blank;

    function automatic logic [15:0] add3(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (w[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Converter: bcd only changes on the LOAD edge, so the display never sees a partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_value <= '0;
            shift      <= '0;
            work       <= '0;
            iter       <= '0;
            busy       <= 1'b0;
            bcd        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (value != last_value) begin
                        shift      <= value;
                        last_value <= value;
                        work       <= '0;
                        iter       <= '0;
                        busy       <= 1'b1;
                        state      <= S_CONV;
                    end
                end
                S_CONV: begin
                    {work, shift} <= {add3(work), shift} << 1;
                    iter          <= iter + 4'd1;
                    if (iter == 4'd9) state <= S_LOAD;
                end
                S_LOAD: begin
                    bcd   <= work;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cur_digit = bcd[{digit_idx, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (digit_idx)
                2'd1:    blank = (bcd[15:4] == 12'd0);
                2'd2:    blank = (bcd[15:8] == 8'd0);
                2'd3:    blank = (bcd[15:12] == 4'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    // Scan: free-running refresh counter; an/seg lag the digit index by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
        end else begin
            if (refresh_cnt == CNT_MAX) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an  <= ~(4'b0001 << digit_idx);
            seg <= blank ? 7'b1111111 : seg_code(cur_digit);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_vote_display_driver.sv
// Bench for vote_display_driver: two instances (leading-zero blanking on/off)
// checked against a decimal reference model of the converter and digit scan.
module tb_vote_display_driver;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  value = '0;
    logic [15:0] bcd, bcd_nb;
    logic        busy, busy_nb;
    logic [3:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;

    int checks = 0;
    int failures = 0;
    int n_edges = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    vote_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .bcd(bcd), .busy(busy),
        .an(an), .seg(seg), .dp(dp)
    );

    vote_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .bcd(bcd_nb), .busy(busy_nb),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    always #5 clk = ~clk;

    // Number of clock edges seen since reset was released
    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    function automatic logic [15:0] dec_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int n, input int i, input bit blank_lz);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (blank_lz && i > 0 && n < p) return 7'b1111111;
        return seg_tab[(n / p) % 10];
    endfunction

    task automatic wait_settle(output bit ok);
        int low;
        low = 0;
        ok  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy && !busy_nb) low++;
            else low = 0;
            if (low >= 2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_scan(input int num, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int         idx;
            logic [3:0] exp_an;
            logic [6:0] es, es_nb;
            @(negedge clk);
            idx    = ((n_edges - 1) / RD) % 4;
            exp_an = ~(4'b0001 << idx);
            es     = exp_seg(num, idx, 1'b1);
            es_nb  = exp_seg(num, idx, 1'b0);
            checks++;
            if (an !== exp_an || an_nb !== exp_an) begin
                failures++;
                $display("FAIL scan_an num=%0d digit=%0d got=%b/%b want=%b", num, idx, an, an_nb, exp_an);
            end
            checks++;
            if (seg !== es) begin
                failures++;
                $display("FAIL scan_seg num=%0d digit=%0d got=%b want=%b", num, idx, seg, es);
            end
            checks++;
            if (seg_nb !== es_nb) begin
                failures++;
                $display("FAIL scan_seg_nolz num=%0d digit=%0d got=%b want=%b", num, idx, seg_nb, es_nb);
            end
            checks++;
            if (dp !== 1'b1) begin
                failures++;
                $display("FAIL scan_dp got=%b want=1", dp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bcd !== 16'h0 || busy !== 1'b0 || an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got bcd=%h busy=%b an=%b seg=%b dp=%b want 0000/0/1111/1111111/1",
                     bcd, busy, an, seg, dp);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_first_scan got an=%b seg=%b want an=1110 seg=1000000", an, seg);
        end
    endtask

    task automatic test_convert_1023();
        int cnt;
        bit first, partial_bad;
        cnt = 0;
        first = 1'b0;
        partial_bad = 1'b0;
        @(negedge clk);
        value = 10'd1023;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) first = busy;
            if (busy) begin
                cnt++;
                if (bcd !== 16'h0) partial_bad = 1'b1;
            end else if (cnt > 0) begin
                break;
            end
        end
        checks++;
        if (first !== 1'b1) begin
            failures++;
            $display("FAIL conv_start busy got=%b want=1", first);
        end
        checks++;
        if (cnt != 11) begin
            failures++;
            $display("FAIL conv_busy_len got=%0d want=11", cnt);
        end
        checks++;
        if (partial_bad) begin
            failures++;
            $display("FAIL conv_partial bcd changed while busy, want it held at 0000");
        end
        checks++;
        if (bcd !== dec_bcd(1023) || bcd_nb !== dec_bcd(1023)) begin
            failures++;
            $display("FAIL conv_1023 got=%h/%h want=%h", bcd, bcd_nb, dec_bcd(1023));
        end
        check_scan(1023, 16);
    endtask

    task automatic test_blanking();
        bit ok;
        @(negedge clk);
        value = 10'd7;
        wait_settle(ok);
        checks++;
        if (!ok || bcd !== dec_bcd(7)) begin
            failures++;
            $display("FAIL blank_bcd settled=%0d got=%h want=%h", ok, bcd, dec_bcd(7));
        end
        check_scan(7, 16);
    endtask

    task automatic test_back_to_back();
        bit ok;
        @(negedge clk);
        value = 10'd5;
        wait_settle(ok);
        value = 10'd999;
        repeat (3) @(negedge clk);
        value = 10'd250;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (bcd !== 16'h0999) begin
            failures++;
            $display("FAIL b2b_first got=%h want=0999", bcd);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart busy got=%b want=1", busy);
        end
        wait_settle(ok);
        checks++;
        if (!ok || bcd !== 16'h0250) begin
            failures++;
            $display("FAIL b2b_final settled=%0d got=%h want=0250", ok, bcd);
        end
        check_scan(250, 16);
    endtask

    task automatic test_reset_abort();
        bit ok;
        @(negedge clk);
        value = 10'd512;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy got=%b want=1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bcd !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got bcd=%h busy=%b want 0000/0", bcd, busy);
        end
        rst = 1'b0;
        wait_settle(ok);
        checks++;
        if (!ok || bcd !== 16'h0512) begin
            failures++;
            $display("FAIL abort_reconvert settled=%0d got=%h want=0512", ok, bcd);
        end
        check_scan(512, 16);
    endtask

    task automatic test_random();
        bit ok;
        int v;
        for (int n = 0; n < 40; n++) begin
            v = $urandom_range(0, 1023);
            @(negedge clk);
            value = 10'(v);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 12)) @(negedge clk);
                v = $urandom_range(0, 1023);
                value = 10'(v);
            end
            wait_settle(ok);
            checks++;
            if (!ok || bcd !== dec_bcd(v) || bcd_nb !== dec_bcd(v)) begin
                failures++;
                $display("FAIL random_bcd value=%0d settled=%0d got=%h/%h want=%h", v, ok, bcd, bcd_nb, dec_bcd(v));
            end
            check_scan(v, 16);
        end
    endtask

    task automatic test_sweep();
        bit ok;
        for (int v = 0; v < 1024; v++) begin
            @(negedge clk);
            value = 10'(v);
            wait_settle(ok);
            checks++;
            if (!ok || bcd !== dec_bcd(v)) begin
                failures++;
                $display("FAIL sweep value=%0d settled=%0d got=%h want=%h", v, ok, bcd, dec_bcd(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert_1023();
        test_blanking();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
